// File: rtl/execute_cycle.sv
// RV32I execute stage: operand forwarding, ALU, 32-step shift-add multiplier, branch resolve, EX/MEM register.
// Optional BRANCH_FULL_EN macro enables the full funct3 branch condition set (default: beq only).
module execute_cycle #(
  parameter int XLEN       = 32,
  parameter int MUL_CYCLES = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            RegWriteE,
  input  logic            MemWriteE,
  input  logic            ResultSrcE,
  input  logic            ALUSrcE,
  input  logic            BranchE,
  input  logic [2:0]      ALUControlE,
  input  logic [2:0]      funct3E,
  input  logic [XLEN-1:0] RD1_E,
  input  logic [XLEN-1:0] RD2_E,
  input  logic [XLEN-1:0] Imm_Ext_E,
  input  logic [XLEN-1:0] PCE,
  input  logic [XLEN-1:0] PCPlus4E,
  input  logic [4:0]      RD_E,
  input  logic [XLEN-1:0] ResultW,
  input  logic [1:0]      ForwardA_E,
  input  logic [1:0]      ForwardB_E,
  output logic            PCSrcE,
  output logic [XLEN-1:0] PCTargetE,
  output logic            StallE,
  output logic            RegWriteM,
  output logic            MemWriteM,
  output logic            ResultSrcM,
  output logic [4:0]      RD_M,
  output logic [XLEN-1:0] PCPlus4M,
  output logic [XLEN-1:0] WriteDataM,
  output logic [XLEN-1:0] ALU_ResultM
);

  localparam int CW = $clog2(MUL_CYCLES);
  localparam logic [CW-1:0] LAST_COUNT = CW'(MUL_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t          state_reg, state_next;
  logic [XLEN-1:0] mcand_reg, mplier_reg, acc_reg;
  logic [CW-1:0]   count_reg;

  logic [1:0]      fwd_sel [2];
  logic [XLEN-1:0] fwd_reg_val [2];
  logic [XLEN-1:0] fwd_out [2];
  logic [XLEN-1:0] src_a, src_b, write_data;
  logic [XLEN-1:0] sum, diff, alu_result;
  logic            zero, lt_s, is_mul, stall_e, mul_done, branch_cond;

  assign fwd_sel[0]     = ForwardA_E;
  assign fwd_sel[1]     = ForwardB_E;
  assign fwd_reg_val[0] = RD1_E;
  assign fwd_reg_val[1] = RD2_E;

  // Code 11 falls through to the register-file value
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
      always_comb begin
        case (fwd_sel[gi])
          2'b01:   fwd_out[gi] = ResultW;
          2'b10:   fwd_out[gi] = ALU_ResultM;
          default: fwd_out[gi] = fwd_reg_val[gi];
        endcase
      end
    end
  endgenerate

  assign src_a      = fwd_out[0];
  assign write_data = fwd_out[1];
  assign src_b      = ALUSrcE ? Imm_Ext_E : write_data;

  assign sum    = src_a + src_b;
  assign diff   = src_a - src_b;
  assign zero   = (diff == '0);
  assign lt_s   = $signed(src_a) < $signed(src_b);
  assign is_mul = (ALUControlE == 3'b100);

  always_comb begin
    case (ALUControlE)
      3'b000:  alu_result = sum;
      3'b001:  alu_result = diff;
      3'b010:  alu_result = src_a & src_b;
      3'b011:  alu_result = src_a | src_b;
      3'b101:  alu_result = {{(XLEN-1){1'b0}}, lt_s};
      default: alu_result = '0;
    endcase
  end

`ifdef BRANCH_FULL_EN
  logic lt_u;
  assign lt_u = src_a < src_b;

  always_comb begin
    case (funct3E)
      3'b000:  branch_cond = zero;
      3'b001:  branch_cond = ~zero;
      3'b100:  branch_cond = lt_s;
      3'b101:  branch_cond = ~lt_s;
      3'b110:  branch_cond = lt_u;
      3'b111:  branch_cond = ~lt_u;
      default: branch_cond = 1'b0;
    endcase
  end
`else
  logic unused_funct3;
  assign unused_funct3 = ^funct3E;
  assign branch_cond   = zero;
`endif

  assign PCTargetE = PCE + Imm_Ext_E;
  assign PCSrcE    = rst & BranchE & branch_cond & ~stall_e;
  assign StallE    = stall_e;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= S_IDLE;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (is_mul) state_next = S_BUSY;
      S_BUSY:  if (count_reg == LAST_COUNT) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Stall is masked during reset so an aborted MUL releases the front end at once
  always_comb begin
    stall_e  = 1'b0;
    mul_done = 1'b0;
    case (state_reg)
      S_IDLE:  stall_e  = rst & is_mul;
      S_BUSY:  stall_e  = rst;
      S_DONE:  mul_done = 1'b1;
      default: stall_e  = 1'b0;
    endcase
  end

  // Operands are captured in the IDLE cycle; forward sources move while stalled
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mcand_reg  <= '0;
      mplier_reg <= '0;
      acc_reg    <= '0;
      count_reg  <= '0;
    end else if (state_reg == S_IDLE && is_mul) begin
      mcand_reg  <= src_a;
      mplier_reg <= src_b;
      acc_reg    <= '0;
      count_reg  <= '0;
    end else if (state_reg == S_BUSY) begin
      if (mplier_reg[0]) acc_reg <= acc_reg + mcand_reg;
      mcand_reg  <= mcand_reg << 1;
      mplier_reg <= mplier_reg >> 1;
      count_reg  <= count_reg + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      RegWriteM   <= 1'b0;
      MemWriteM   <= 1'b0;
      ResultSrcM  <= 1'b0;
      RD_M        <= '0;
      PCPlus4M    <= '0;
      WriteDataM  <= '0;
      ALU_ResultM <= '0;
    end else if (stall_e) begin
      RegWriteM <= 1'b0;
      MemWriteM <= 1'b0;
    end else begin
      RegWriteM   <= RegWriteE;
      MemWriteM   <= MemWriteE;
      ResultSrcM  <= ResultSrcE;
      RD_M        <= RD_E;
      PCPlus4M    <= PCPlus4E;
      WriteDataM  <= write_data;
      ALU_ResultM <= mul_done ? acc_reg : alu_result;
    end
  end

endmodule

// File: doc/execute_cycle.md
Name: execute_cycle

Overview:
Execute stage of the 5-stage RV32I pipeline, directly upstream of the memory stage. It does the following:
- Selects forwarded operands.
- Runs the single-cycle ALU or a 32-cycle iterative multiplier.
- Resolves branches.
- Owns the EX/MEM pipeline register that feeds the memory stage.

While a multiply is in progress it stalls the front end and injects bubbles into MEM.

Parameters:
XLEN, 32, datapath width
MUL_CYCLES, 32, shift-add iterations per MUL; must equal XLEN

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-low reset
RegWriteE, MemWriteE, ResultSrcE, ALUSrcE, BranchE  input  1 each  ID/EX control
ALUControlE  input  3  000 add, 001 sub, 010 and, 011 or, 101 slt, 100 mul (low 32 bits)
funct3E  input  3  branch condition select (used only under BRANCH_FULL_EN)
RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E  input  32 each  ID/EX data
RD_E  input  5  destination register
ResultW  input  32  writeback forward source
ForwardA_E, ForwardB_E  input  2 each  00 RDx_E, 01 ResultW, 10 ALU_ResultM
PCSrcE  output  1  branch taken
PCTargetE  output  32  PCE + Imm_Ext_E
StallE  output  1  hold IF/ID/EX (multiply busy)
RegWriteM, MemWriteM, ResultSrcM  output  1 each  EX/MEM control
RD_M  output  5  EX/MEM destination
PCPlus4M, WriteDataM, ALU_ResultM  output  32 each  EX/MEM data

Behaviour:
- Reset (rst=0, asynchronous):
  - All EX/MEM outputs are 0.
  - FSM is IDLE, multiplier regs and counter are 0.
  - StallE=0, PCSrcE=0.
- Operand select:
  - SrcA = fwd(ForwardA_E).
  - WriteData = fwd(ForwardB_E).
  - SrcB = ALUSrcE ? Imm_Ext_E : WriteData.
  - Forward code 11 is treated as 00.
- ALU:
  - Combinational; add/sub wrap modulo 2^32.
  - slt is signed and gives 32'h1 or 32'h0.
  - Undefined codes give 0.
  - Zero = (sub result == 0).
- Branch:
  - PCSrcE = BranchE & Zero & ~StallE.
  - PCTargetE is always PCE+Imm_Ext_E, wrapping.
- Multiply FSM:
  - IDLE:
    - If ALUControlE==100, latch SrcA/SrcB into multiplicand/multiplier, clear the accumulator and count, and go to BUSY.
    - StallE=1 combinationally in this cycle.
  - BUSY:
    - Each cycle: if multiplier LSB is set, add the multiplicand to the accumulator; shift the multiplicand left and the multiplier right; count++.
    - StallE=1.
    - When count==MUL_CYCLES-1, go to DONE.
  - DONE:
    - StallE=0; the accumulator drives the result.
    - The EX/MEM register captures it with the E-stage controls.
    - Go to IDLE.
  - Total E occupancy of a MUL is 34 cycles, with 33 bubbles.
  - Operands are latched in the IDLE cycle because ResultW/ALU_ResultM change during the stall.
- EX/MEM register (posedge clk):
  - If StallE=1, load a bubble: RegWriteM=0, MemWriteM=0, other fields unchanged.
  - Otherwise load the E-stage values, with ALU_ResultM = mul result in DONE, else the ALU result.
- Simultaneous events:
  - A MUL with BranchE=1 is illegal (decoder guarantees this); PCSrcE stays 0 while StallE.
  - A MUL immediately after a MUL: DONE returns to IDLE, and the next MUL starts in the following cycle.
- Reset mid-multiply aborts the operation. No result is written; StallE drops immediately.

Optional Feature:
BRANCH_FULL_EN:
- Defined: funct3E selects the taken condition (000 beq, 001 bne, 100 blt, 101 bge, 110 bltu, 111 bgeu; others never taken), gated by BranchE & ~StallE.
- Undefined: funct3E is ignored and only beq is supported (PCSrcE = BranchE & Zero & ~StallE).

Test Plan:
1. Reset: rst=0 asserted mid-run -> all outputs 0 asynchronously. After release, add RD1_E=5, RD2_E=7, ALUSrcE=0 -> ALU_ResultM=12 one clock later.
2. Forwarding:
   - ForwardA_E=10, ALU_ResultM=0x10, Imm_Ext_E=4, ALUSrcE=1, ALUControlE=000 -> ALU_ResultM=0x14.
   - ForwardB_E=01, ResultW=0xAB, MemWriteE=1 -> WriteDataM=0xAB.
3. Branch:
   - beq with RD1_E=RD2_E=3, PCE=0x100, Imm_Ext_E=0x20 -> PCSrcE=1, PCTargetE=0x120.
   - Unequal operands -> PCSrcE=0.
   - With BRANCH_FULL_EN, bltu with 1 vs 0xFFFFFFFF -> PCSrcE=1.
4. Multiply:
   - MUL 0xFFFFFFFF × 3, RegWriteE=1 -> StallE=1 for 33 cycles and RegWriteM=0 on those edges.
   - Then ALU_ResultM=0xFFFFFFFD with RegWriteM=1.
   - ResultW toggled during the stall does not affect the result.
5. Back-to-back MULs 6×7 then 2×2 -> results 42 and 4 in order, each after 34 cycles, with no lost or duplicated write.
6. Reset in BUSY cycle 10 -> FSM IDLE, StallE=0, no MEM write of a partial result.
